dadda_mac_pipe: RTL and testbench

//  Parametrised, pipelined multiply-accumulate unit: result = A*B + addend, with the addend either external (C) or the internal accumulator.

---
 rtl/dadda_mac_pipe.sv | 218 +++++++++++++++++++++
 tb/tb_dadda_mac_pipe.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dadda_mac_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : dadda_mac_pipe
//  Function : Two-stage pipelined MAC (Dadda tree + Brent-Kung adder) with
//             accumulator, signed/unsigned mode, saturation and valid/ready.
//  Revision : 1.0  initial release
// ============================================================================
module dadda_mac_pipe #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 20,
  parameter bit SAT   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [ACC_W-1:0] c,
  input  logic             mode_signed,
  input  logic             acc_mode,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] result,
  output logic             ovf
);

  localparam int c_PW = 2 * WIDTH;
  localparam int c_NB = c_PW - 1;

  function automatic int dadda_d(input int s);
    int d;
    d = 2;
    for (int i = 0; i < s; i++) d = (d * 3) / 2;
    return d;
  endfunction

  function automatic int dadda_nst(input int h);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) if (dadda_d(i) < h) n = i + 1;
    return n;
  endfunction

  localparam int c_NST = dadda_nst(WIDTH);

  if (ACC_W < 2 * WIDTH || WIDTH < 2) begin : g_param_check
    $error("dadda_mac_pipe: requires WIDTH >= 2 and ACC_W >= 2*WIDTH");
  end

  logic [c_PW-1:0]  row_a, row_b, prod_d;
  logic             s1_valid_q, sgn_q, mode_q, clr_q;
  logic [c_PW-1:0]  prod_q;
  logic [ACC_W-1:0] c_q;
  logic             out_valid_q, ovf_q, ovf_d;
  logic [ACC_W-1:0] result_q, result_d;
  logic             s1_adv, s2_adv;

  // Modified Baugh-Wooley partial products: in signed mode the cross terms
  // with exactly one sign bit are inverted and 1s are added at columns
  // WIDTH and 2*WIDTH-1; in unsigned mode this is the plain AND array.
  always_comb begin : p_dadda
    logic [WIDTH-1:0] cur [c_PW];
    logic [WIDTH-1:0] nxt [c_PW];
    int               ch  [c_PW];
    int               nh  [c_PW];
    int               idx, d, nc;
    logic             x, y, z;
    idx = 0; d = 0; nc = 0; x = 1'b0; y = 1'b0; z = 1'b0;
    for (int k = 0; k < c_PW; k++) begin
      cur[k] = '0; nxt[k] = '0; ch[k] = 0; nh[k] = 0;
    end
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        cur[i+j][ch[i+j]] = (a[j] & b[i]) ^
                            (mode_signed & ((i == WIDTH-1) != (j == WIDTH-1)));
        ch[i+j] = ch[i+j] + 1;
      end
    end
    cur[WIDTH][ch[WIDTH]] = mode_signed;
    ch[WIDTH] = ch[WIDTH] + 1;
    cur[c_PW-1][ch[c_PW-1]] = mode_signed;
    ch[c_PW-1] = ch[c_PW-1] + 1;

    for (int s = c_NST - 1; s >= 0; s--) begin
      d = dadda_d(s);
      for (int k = 0; k < c_PW; k++) begin
        nxt[k] = '0; nh[k] = 0;
      end
      for (int col = 0; col < c_PW; col++) begin
        idx = 0;
        nc  = (col + 1 < c_PW) ? col + 1 : col;
        // nh[col] already counts carries from the column below
        for (int k = 0; k < WIDTH; k++) begin
          if (nh[col] + ch[col] - idx > d) begin
            if ((ch[col] - idx >= 3) && (nh[col] + ch[col] - idx > d + 1)) begin
              x = cur[col][idx]; y = cur[col][idx+1]; z = cur[col][idx+2];
              idx = idx + 3;
            end else begin
              x = cur[col][idx]; y = cur[col][idx+1]; z = 1'b0;
              idx = idx + 2;
            end
            nxt[col][nh[col]] = x ^ y ^ z;
            nh[col] = nh[col] + 1;
            if (col + 1 < c_PW) begin
              nxt[nc][nh[nc]] = (x & y) | (x & z) | (y & z);
              nh[nc] = nh[nc] + 1;
            end
          end
        end
        for (int k = 0; k < WIDTH; k++) begin
          if (k >= idx && k < ch[col]) begin
            nxt[col][nh[col]] = cur[col][k];
            nh[col] = nh[col] + 1;
          end
        end
      end
      for (int k = 0; k < c_PW; k++) begin
        cur[k] = nxt[k]; ch[k] = nh[k];
      end
    end

    for (int k = 0; k < c_PW; k++) begin
      row_a[k] = cur[k][0];
      row_b[k] = cur[k][1];
    end
  end

  always_comb begin : p_brent_kung
    logic [c_NB-1:0] gk, pk;
    logic [c_PW-1:0] p;
    p  = row_a ^ row_b;
    gk = row_a[c_NB-1:0] & row_b[c_NB-1:0];
    pk = p[c_NB-1:0];
    for (int l = 0; l < 16; l++) begin
      for (int i = 0; i < c_NB; i++) begin
        if (((1 << l) < c_NB) && (((i + 1) % (2 << l)) == 0)) begin
          gk[i] = gk[i] | (pk[i] & gk[i-(1<<l)]);
          pk[i] = pk[i] & pk[i-(1<<l)];
        end
      end
    end
    for (int l = 15; l >= 0; l--) begin
      for (int i = 0; i < c_NB; i++) begin
        if ((i >= (3 << l) - 1) && (((i + 1) % (2 << l)) == (1 << l))) begin
          gk[i] = gk[i] | (pk[i] & gk[i-(1<<l)]);
          pk[i] = pk[i] & pk[i-(1<<l)];
        end
      end
    end
    prod_d[0] = p[0];
    for (int i = 1; i < c_PW; i++) prod_d[i] = p[i] ^ gk[i-1];
  end

  assign s2_adv   = !out_valid_q | out_ready;
  assign s1_adv   = !s1_valid_q | s2_adv;
  assign in_ready = s1_adv & !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      prod_q     <= '0;
      sgn_q      <= 1'b0;
      mode_q     <= 1'b0;
      clr_q      <= 1'b0;
      c_q        <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        prod_q <= prod_d;
        sgn_q  <= mode_signed;
        mode_q <= acc_mode;
        clr_q  <= acc_clr;
        c_q    <= c;
      end
    end
  end

  // result_q doubles as the accumulator: both always load the same value.
  always_comb begin : p_stage2
    logic [ACC_W-1:0] ext, addend, sat_val;
    logic [ACC_W:0]   sum;
    ext = '0;
    ext[c_PW-1:0] = prod_q;
    for (int i = c_PW; i < ACC_W; i++) ext[i] = sgn_q & prod_q[c_PW-1];
    addend = mode_q ? (clr_q ? '0 : result_q) : c_q;
    sum    = {1'b0, ext} + {1'b0, addend};
    if (sgn_q) begin
      ovf_d   = (ext[ACC_W-1] == addend[ACC_W-1]) && (sum[ACC_W-1] != ext[ACC_W-1]);
      sat_val = addend[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      ovf_d   = sum[ACC_W];
      sat_val = '1;
    end
    result_d = (SAT && ovf_d) ? sat_val : sum[ACC_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        result_q <= result_d;
        ovf_q    <= ovf_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_dadda_mac_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dadda_mac_pipe
//  Function : Self-checking bench for dadda_mac_pipe (three configurations
//             driven in lockstep) against an integer reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dadda_mac_pipe;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, out_ready, sgn, accm, clr;
  logic [7:0]  a, b;
  logic [19:0] c;
  logic        rdy0, rdy1, rdy2, ov0, ov1, ov2, o0, o1, o2;
  logic [19:0] res0;
  logic [15:0] res1, res2;

  dadda_mac_pipe #(.WIDTH(8), .ACC_W(20), .SAT(1'b1)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .a(a), .b(b),
    .c(c), .mode_signed(sgn), .acc_mode(accm), .acc_clr(clr),
    .out_valid(ov0), .out_ready(out_ready), .result(res0), .ovf(o0));

  dadda_mac_pipe #(.WIDTH(8), .ACC_W(16), .SAT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .a(a), .b(b),
    .c(c[15:0]), .mode_signed(sgn), .acc_mode(accm), .acc_clr(clr),
    .out_valid(ov1), .out_ready(out_ready), .result(res1), .ovf(o1));

  dadda_mac_pipe #(.WIDTH(8), .ACC_W(16), .SAT(1'b0)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .a(a), .b(b),
    .c(c[15:0]), .mode_signed(sgn), .acc_mode(accm), .acc_clr(clr),
    .out_valid(ov2), .out_ready(out_ready), .result(res2), .ovf(o2));

  typedef struct packed {
    logic [19:0] r0; logic o0;
    logic [15:0] r1; logic o1;
    logic [15:0] r2; logic o2;
  } exp_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic [19:0] r0; logic o0;
    logic [15:0] r1; logic o1;
    logic [15:0] r2; logic o2;
  } obs_t;

  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     n_acc = 0;
  bit     rand_done = 1'b0;
  exp_t   sb[$];
  obs_t   obs[$];
  longint acc0 = 0, acc1 = 0, acc2 = 0;
  bit          stall_prev = 1'b0;
  logic [19:0] prev_r0;
  logic        prev_o0;

  always @(posedge clk) cyc++;

  // Exact-integer reference: widen everything, then range-check and clamp.
  function automatic logic [20:0] ref_mac(input int aw, input bit sat,
      input logic [7:0] ta, input logic [7:0] tbv, input logic [19:0] tc,
      input bit ts, input bit tm, input bit tcl, inout longint acc);
    longint modv, pa, pb, cv, av, addv, sum, maxv, minv, r;
    bit     ov;
    modv = longint'(1) << aw;
    pa   = ts ? longint'($signed(ta))  : longint'(ta);
    pb   = ts ? longint'($signed(tbv)) : longint'(tbv);
    cv   = longint'(tc) & (modv - 1);
    av   = acc;
    if (ts && cv >= modv / 2) cv = cv - modv;
    if (ts && av >= modv / 2) av = av - modv;
    addv = tm ? (tcl ? 0 : av) : cv;
    sum  = pa * pb + addv;
    maxv = ts ? modv / 2 - 1 : modv - 1;
    minv = ts ? -(modv / 2) : 0;
    ov   = (sum > maxv) || (sum < minv);
    if (ov && sat) sum = (sum > maxv) ? maxv : minv;
    r    = sum & (modv - 1);
    acc  = r;
    return {ov, r[19:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [7:0] ta, input logic [7:0] tbv, input logic [19:0] tc,
                       input bit ts, input bit tm, input bit tcl);
    bit          got;
    int          n;
    logic [20:0] r;
    exp_t        e;
    a = ta; b = tbv; c = tc; sgn = ts; accm = tm; clr = tcl; in_valid = 1'b1;
    got = 1'b0; n = 0;
    while (!got && n < 200) begin
      @(negedge clk);
      got = (rdy0 === 1'b1);
      @(posedge clk); #1;
      n++;
    end
    checks++;
    assert (got)
    else begin
      errors++;
      $error("FAIL accept_timeout: observed in_ready low for %0d cycles, expected accept", n);
    end
    if (got) begin
      r = ref_mac(20, 1'b1, ta, tbv, tc, ts, tm, tcl, acc0); e.r0 = r[19:0]; e.o0 = r[20];
      r = ref_mac(16, 1'b1, ta, tbv, tc, ts, tm, tcl, acc1); e.r1 = r[15:0]; e.o1 = r[20];
      r = ref_mac(16, 1'b0, ta, tbv, tc, ts, tm, tcl, acc2); e.r2 = r[15:0]; e.o2 = r[20];
      sb.push_back(e);
      n_acc++;
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        assert (ov0 === 1'b1 && res0 === prev_r0 && o0 === prev_o0)
        else begin
          errors++;
          $error("FAIL stall_hold: observed valid=%0b res=%0d ovf=%0b, expected valid=1 res=%0d ovf=%0b",
                 ov0, res0, o0, prev_r0, prev_o0);
        end
      end
      if (ov0 === 1'b1 && out_ready === 1'b1) begin
        checks++;
        assert (sb.size() != 0)
        else begin
          errors++;
          $error("FAIL spurious_out: observed result %0d, expected no output", res0);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          checks++;
          assert (res0 === e.r0 && o0 === e.o0 && ov1 === 1'b1 && res1 === e.r1 &&
                  o1 === e.o1 && ov2 === 1'b1 && res2 === e.r2 && o2 === e.o2)
          else begin
            errors++;
            $error("FAIL result: observed %0d/%0b %0d/%0b %0d/%0b, expected %0d/%0b %0d/%0b %0d/%0b",
                   res0, o0, res1, o1, res2, o2, e.r0, e.o0, e.r1, e.o1, e.r2, e.o2);
          end
        end
        obs.push_back({cyc[31:0], res0, o0, res1, o1, res2, o2});
      end
      stall_prev = (ov0 === 1'b1 && out_ready === 1'b0);
      prev_r0    = res0;
      prev_o0    = o0;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; c = '0; sgn = 1'b0; accm = 1'b0; clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", ov0, 0);
    chk("rst_result", res0, 0);
    chk("rst_ovf", o0, 0);
    chk("rst_in_ready", rdy0, 0);
    chk("rst_result16", res1, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // unsigned max operands, external addend, latency
    drive(8'd255, 8'd255, 20'd1, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_not_yet", ov0, 0);
    @(negedge clk);
    chk("lat_valid", ov0, 1);
    chk("t1_result", res0, 65026);
    chk("t1_ovf", o0, 0);
    idle(3);

    // signed external addend
    obs.delete();
    drive(8'h80, 8'h80, 20'hFFFFF, 1'b1, 1'b0, 1'b0);
    drive(8'hFF, 8'd127, 20'd0, 1'b1, 1'b0, 1'b0);
    idle(4);
    chk("t2_count", obs.size(), 2);
    if (obs.size() >= 2) begin
      chk("t2_r0_a", obs[0].r0, 16383);
      chk("t2_r0_b", obs[1].r0, 20'hFFF81);
      chk("t2_r1_b", obs[1].r1, 16'hFF81);
    end

    // back-to-back accumulate
    obs.delete();
    drive(8'd3, 8'd4, 20'd0, 1'b1, 1'b1, 1'b1);
    drive(8'd5, 8'd6, 20'd0, 1'b1, 1'b1, 1'b0);
    drive(8'hFE, 8'd7, 20'd0, 1'b1, 1'b1, 1'b0);
    idle(4);
    chk("t3_count", obs.size(), 3);
    if (obs.size() >= 3) begin
      chk("t3_acc1", obs[0].r0, 12);
      chk("t3_acc2", obs[1].r0, 42);
      chk("t3_acc3", obs[2].r0, 28);
      chk("t3_consec", obs[2].cyc - obs[0].cyc, 2);
    end

    // accumulator overflow: saturate vs wrap at 16 bits
    obs.delete();
    drive(8'd127, 8'd127, 20'd0, 1'b1, 1'b1, 1'b1);
    drive(8'd127, 8'd127, 20'd0, 1'b1, 1'b1, 1'b0);
    drive(8'd127, 8'd127, 20'd0, 1'b1, 1'b1, 1'b0);
    idle(4);
    chk("t4_count", obs.size(), 3);
    if (obs.size() >= 3) begin
      chk("t4_sat1", obs[0].r1, 16129);
      chk("t4_sat2", obs[1].r1, 32258);
      chk("t4_sat2_ovf", obs[1].o1, 0);
      chk("t4_sat3", obs[2].r1, 32767);
      chk("t4_sat3_ovf", obs[2].o1, 1);
      chk("t4_wrap3", obs[2].r2, 16'hBD03);
      chk("t4_wrap3_ovf", obs[2].o2, 1);
      chk("t4_wide3", obs[2].r0, 48387);
    end

    // backpressure
    obs.delete();
    n_acc = 0;
    out_ready = 1'b0;
    fork
      begin
        drive(8'd10, 8'd11, 20'd5, 1'b0, 1'b0, 1'b0);
        drive(8'd12, 8'd13, 20'd6, 1'b0, 1'b0, 1'b0);
        drive(8'd14, 8'd15, 20'd7, 1'b0, 1'b0, 1'b0);
        drive(8'd16, 8'd17, 20'd8, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready", rdy0, 0);
        chk("bp_accepted", n_acc, 2);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    idle(6);
    chk("t5_count", obs.size(), 4);
    if (obs.size() >= 4) begin
      chk("t5_r0", obs[0].r0, 115);
      chk("t5_r1", obs[1].r0, 162);
      chk("t5_r2", obs[2].r0, 217);
      chk("t5_r3", obs[3].r0, 280);
    end

    // reset with beats in flight
    obs.delete();
    drive(8'd20, 8'd25, 20'd0, 1'b0, 1'b1, 1'b1);
    idle(4);
    chk("t6_acc500", obs.size() >= 1 ? obs[0].r0 : 20'h0, 500);
    out_ready = 1'b0;
    drive(8'd2, 8'd2, 20'd0, 1'b0, 1'b0, 1'b0);
    drive(8'd3, 8'd3, 20'd0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    sb.delete();
    acc0 = 0; acc1 = 0; acc2 = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_valid_cleared", ov0, 0);
    chk("t6_ready_in_rst", rdy0, 0);
    chk("t6_result_cleared", res0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    obs.delete();
    @(negedge clk);
    chk("t6_ready_after_rst", rdy0, 1);
    @(posedge clk); #1;
    drive(8'd2, 8'd3, 20'd0, 1'b0, 1'b1, 1'b0);
    idle(5);
    chk("t6_count", obs.size(), 1);
    chk("t6_first", obs.size() >= 1 ? obs[0].r0 : 20'h0, 6);

    // randomized traffic with random backpressure
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          drive(8'($urandom), 8'($urandom), 20'($urandom), 1'($urandom),
                1'($urandom), ($urandom_range(0, 3) == 0));
          if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 2));
        end
        in_valid = 1'b0;
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    for (int i = 0; i < 100 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("drain_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
